// File: rtl/param_memory_pkg.sv
// param_memory_pkg: shared FSM state encoding and read-latency limits for param_memory.
package param_memory_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, RESP, HOLD} state_t;
    localparam int RAM_LATENCY_MIN = 1;
    localparam int RAM_LATENCY_MAX = 4;
    localparam int CNT_W = $clog2(RAM_LATENCY_MAX);
endpackage

// File: rtl/byte_write_ram.sv
// byte_write_ram: single-port byte-enabled RAM with a LATENCY-stage registered read pipeline.
module byte_write_ram #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] pipe [LATENCY];
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
            if (we && be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        pipe[0] <= mem[addr];
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata = pipe[LATENCY-1];
endmodule

// File: rtl/param_memory.sv
// param_memory: two-port (write/read) request/ready front end arbitrating onto one byte-write RAM.
module param_memory import param_memory_pkg::*; #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LATENCY = 1,
    parameter bit WRITE_FIRST_PRIORITY = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             out_addr,
    input  logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_ready,
    output logic                    busy
);
    localparam int OFS = $clog2(DATA_WIDTH/8);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic last_wr;
    logic grant_wr, grant_rd, ram_we;
    logic [ADDR_WIDTH-1:0] wr_idx, ram_addr;
    logic [DATA_WIDTH-1:0] wr_data, ram_rdata;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic unused_bits;
    assign unused_bits = ^{in_addr, out_addr};
    // last_wr=0 means read was granted last, so a tie goes to the write port
    assign grant_wr = state == IDLE && in_valid && (!out_valid || WRITE_FIRST_PRIORITY || !last_wr);
    assign grant_rd = state == IDLE && out_valid && !grant_wr;
    assign ram_we = state == WRITE;
    assign ram_addr = ram_we ? wr_idx : out_addr[ADDR_WIDTH+OFS-1:OFS];
    assign in_ready = state == WRITE;
    assign out_ready = state == RESP;
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                if (grant_wr) state_nx = WRITE;
                else if (grant_rd) begin
                    state_nx = READ_WAIT;
                    cnt_nx = CNT_W'(RAM_LATENCY - 1);
                end
            end
            WRITE: state_nx = HOLD;
            READ_WAIT: begin
                if (cnt == '0) state_nx = RESP;
                else cnt_nx = cnt - 1'b1;
            end
            RESP: state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            last_wr <= 1'b0;
            out_data <= '0;
            wr_idx <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (grant_wr) begin
                wr_idx <= in_addr[ADDR_WIDTH+OFS-1:OFS];
                wr_data <= in_data;
                wr_strb <= in_strb;
                last_wr <= 1'b1;
            end
            if (grant_rd) last_wr <= 1'b0;
            if (state == READ_WAIT && cnt == '0) out_data <= ram_rdata;
        end
    end
    byte_write_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY(RAM_LATENCY)
    ) u_ram (
        .clk(clk),
        .we(ram_we),
        .be(wr_strb),
        .addr(ram_addr),
        .wdata(wr_data),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: vector table, hand sequences and randomized traffic against a word-array model.
module tb_param_memory;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_in_addr = 0, a_in_data = 0, a_out_addr = 0, a_out_data;
    logic [3:0] a_in_strb = 0;
    logic a_in_valid = 0, a_in_ready, a_out_valid = 0, a_out_ready, a_busy;
    logic [31:0] b_in_addr = 0, b_in_data = 0, b_out_addr = 0, b_out_data;
    logic [3:0] b_in_strb = 0;
    logic b_in_valid = 0, b_in_ready, b_out_valid = 0, b_out_ready, b_busy;

    param_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RAM_LATENCY(3), .WRITE_FIRST_PRIORITY(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_addr(a_in_addr), .in_data(a_in_data), .in_strb(a_in_strb), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_addr(a_out_addr), .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .busy(a_busy)
    );
    param_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RAM_LATENCY(1), .WRITE_FIRST_PRIORITY(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .in_addr(b_in_addr), .in_data(b_in_data), .in_strb(b_in_strb), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_addr(b_out_addr), .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .busy(b_busy)
    );

    int n_checks = 0, n_fail = 0;
    logic [31:0] mem1 [16];

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int idx1(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (a_busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %0b", a_busy);
        end
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        @(negedge clk);
        wait_idle();
        a_in_addr = a; a_in_data = d; a_in_strb = s; a_in_valid = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_in_ready && lat < 40);
        a_in_valid = 0;
        lat = a_in_ready ? lat + 1 : -1;
        for (int b = 0; b < 4; b++)
            if (s[b]) mem1[idx1(a)][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic rd1(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        wait_idle();
        a_out_addr = a; a_out_valid = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_out_ready && lat < 40);
        a_out_valid = 0;
        d = a_out_data;
        lat = a_out_ready ? lat + 1 : -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t, gw, gr, n;
        logic [31:0] d, first_rd;
        logic [3:0] order;
        logic [31:0] a, wd;
        logic [3:0] s;
        vecs[0] = '{32'h40, 32'hDEADBEEF, 4'hF, 32'h40, 32'hDEADBEEF};
        vecs[1] = '{32'h84, 32'hFFFFFFFF, 4'hF, 32'h84, 32'hFFFFFFFF};
        vecs[2] = '{32'h84, 32'h11223344, 4'h5, 32'h84, 32'hFF22FF44};
        vecs[3] = '{32'h40, 32'h00000007, 4'hF, 32'h00, 32'h00000007};
        vecs[4] = '{32'h84, 32'h12345678, 4'h0, 32'h84, 32'hFF22FF44};
        vecs[5] = '{32'h0A, 32'hCAFEF00D, 4'hF, 32'h08, 32'hCAFEF00D};
        vecs[6] = '{32'hFFFFFFFC, 32'h0BADC0DE, 4'hF, 32'h3C, 32'h0BADC0DE};

        #12;
        chk("rst_in_ready", {31'b0, a_in_ready}, 0);
        chk("rst_out_ready", {31'b0, a_out_ready}, 0);
        chk("rst_busy", {30'b0, a_busy, b_busy}, 0);
        chk("rst_out_data", a_out_data, 0);
        @(negedge clk);
        reset = 1;

        b_in_addr = 32'h10; b_in_data = 32'h55AA55AA; b_in_strb = 4'hF; b_out_addr = 32'h10;
        b_in_valid = 1; b_out_valid = 1;
        order = 0; t = 0; n = 0; first_rd = 0;
        while (n < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (b_in_ready) begin order = {order[2:0], 1'b1}; n++; end
            if (b_out_ready) begin
                if (first_rd == 0) first_rd = b_out_data;
                order = {order[2:0], 1'b0};
                n++;
            end
        end
        b_in_valid = 0; b_out_valid = 0;
        chk("rr_grant_count", n, 4);
        chk("rr_order_WRWR", {28'b0, order}, 32'hA);
        chk("rr_first_read", first_rd, 32'h55AA55AA);

        for (int i = 0; i < 16; i++) wr1(i * 4, $urandom, 4'hF, lat);

        for (int i = 0; i < 7; i++) begin
            wr1(vecs[i].wa, vecs[i].wd, vecs[i].ws, lat);
            chk($sformatf("row%0d_wr_lat", i), lat, 2);
            rd1(vecs[i].ra, d, lat);
            chk($sformatf("row%0d_rd_lat", i), lat, 5);
            chk($sformatf("row%0d_rd_data", i), d, vecs[i].exp);
        end

        @(negedge clk);
        wait_idle();
        a_in_addr = 32'h8; a_in_data = 32'hA5A5A5A5; a_in_strb = 4'hF; a_out_addr = 32'h8;
        a_in_valid = 1; a_out_valid = 1;
        gw = 0; gr = 0; t = 0; d = 0;
        while (gr == 0 && t < 40) begin
            @(negedge clk);
            t++;
            if (a_in_ready) begin gw = t; a_in_valid = 0; end
            if (a_out_ready) begin gr = t; a_out_valid = 0; d = a_out_data; end
        end
        a_in_valid = 0; a_out_valid = 0;
        mem1[2] = 32'hA5A5A5A5;
        chk("prio_w_cycle", gw, 1);
        chk("prio_r_cycle", gr, 7);
        chk("prio_rd_data", d, 32'hA5A5A5A5);

        @(negedge clk);
        wait_idle();
        a_in_addr = 32'hC; a_in_data = 32'h13579BDF; a_in_strb = 4'hF; a_in_valid = 1;
        @(negedge clk);
        a_in_addr = 32'h10; a_in_data = 32'h0; a_in_strb = 4'h0; a_in_valid = 0;
        chk("late_change_wr_ready", {31'b0, a_in_ready}, 1);
        mem1[3] = 32'h13579BDF;
        @(negedge clk);
        wait_idle();
        a_out_addr = 32'hC; a_out_valid = 1;
        @(negedge clk);
        a_out_valid = 0; a_out_addr = 32'h10;
        t = 1;
        while (!a_out_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("dropped_valid_rd_cycle", t, 4);
        chk("late_change_rd_data", a_out_data, 32'h13579BDF);
        @(negedge clk);
        chk("out_ready_one_cycle", {31'b0, a_out_ready}, 0);
        repeat (3) @(negedge clk);
        chk("out_data_held", a_out_data, 32'h13579BDF);
        rd1(32'h10, d, lat);
        chk("late_change_other_word", d, mem1[4]);

        repeat (40) begin
            a = $urandom;
            if ($urandom_range(1) == 1) begin
                wd = $urandom;
                s = 4'($urandom_range(15));
                wr1(a, wd, s, lat);
                chk("rand_wr_lat", lat, 2);
            end else begin
                rd1(a, d, lat);
                chk("rand_rd_lat", lat, 5);
                chk($sformatf("rand_rd_data_%0h", a), d, mem1[idx1(a)]);
            end
        end

        @(negedge clk);
        wait_idle();
        a_out_addr = 32'h0; a_out_valid = 1;
        repeat (2) @(negedge clk);
        chk("mid_read_busy", {31'b0, a_busy}, 1);
        reset = 0; a_out_valid = 0;
        #1;
        chk("rst_mid_busy", {31'b0, a_busy}, 0);
        chk("rst_mid_out_ready", {31'b0, a_out_ready}, 0);
        chk("rst_mid_in_ready", {31'b0, a_in_ready}, 0);
        chk("rst_mid_out_data", a_out_data, 0);
        @(negedge clk);
        reset = 1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_out_ready) n++;
        end
        chk("rst_no_out_ready", n, 0);
        rd1(32'h0, d, lat);
        chk("post_rst_rd_lat", lat, 5);
        chk("post_rst_rd_data", d, mem1[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: word-address bits; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits; multiple of 8, at least 8.
REQ-003 Parameter RAM_LATENCY, default 1, range 1..4: read pipeline depth of the storage array in cycles.
REQ-004 Parameter WRITE_FIRST_PRIORITY, default 1: 1 = write wins every conflict; 0 = round-robin between ports.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_addr  in  32  write byte address.
REQ-008 in_data  in  DATA_WIDTH  write data.
REQ-009 in_strb  in  DATA_WIDTH/8  byte write enables; bit i covers byte i.
REQ-010 in_valid  in  1  write request, held until in_ready.
REQ-011 in_ready  out  1  one-cycle pulse: write committed.
REQ-012 out_addr  in  32  read byte address.
REQ-013 out_valid  in  1  read request, held until out_ready.
REQ-014 out_data  out  DATA_WIDTH  read data, valid while out_ready=1 and held until the next read completes.
REQ-015 out_ready  out  1  one-cycle pulse: out_data valid.
REQ-016 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-017 Word index SHALL be addr[ADDR_WIDTH+OFS-1:OFS] with OFS = log2(DATA_WIDTH/8); higher bits and offset bits SHALL be ignored, so out-of-range addresses wrap.
REQ-018 The FSM SHALL have states IDLE, WRITE, READ_WAIT, RESP, HOLD.
REQ-019 In IDLE with only in_valid: go to WRITE and drive the array write of the masked bytes for exactly one edge.
REQ-020 WRITE SHALL assert in_ready for one cycle, then go to HOLD.
REQ-021 In IDLE with only out_valid: issue the array read and go to READ_WAIT with a latency counter loaded to RAM_LATENCY-1.
REQ-022 READ_WAIT SHALL decrement the counter; at zero it SHALL capture array output into out_data and go to RESP.
REQ-023 RESP SHALL assert out_ready for one cycle, then go to HOLD.
REQ-024 Read latency SHALL be exactly RAM_LATENCY+2 cycles from the IDLE grant edge to out_ready high; write latency SHALL be exactly 2 cycles.
REQ-025 HOLD SHALL last one cycle and return to IDLE, so a requester must drop valid the cycle after ready; a valid still high in IDLE is a new request.
REQ-026 On a simultaneous in_valid and out_valid in IDLE with WRITE_FIRST_PRIORITY=1, write SHALL be granted; the read stays pending.
REQ-027 With WRITE_FIRST_PRIORITY=0, a simultaneous request SHALL be granted to the port not granted last; the last-grant register resets to "read" so write wins first.
REQ-028 Address and data SHALL be sampled only at the grant edge; later changes SHALL not affect the transaction.
REQ-029 A read of a word written by a completed transaction SHALL return the new data; in_strb=0 SHALL leave the word unchanged but still pulse in_ready.
REQ-030 Valid dropped mid-transaction SHALL NOT abort it; the ready pulse still occurs.

Reset
REQ-031 While reset=0: state=IDLE, in_ready=0, out_ready=0, busy=0, out_data=0, counter=0, last-grant=read, array write enable=0.
REQ-032 Reset mid-transaction SHALL discard it with no ready pulse; array contents are undefined after an interrupted write, otherwise preserved.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the RAM_LATENCY range limits.
REQ-034 Storage SHALL be one sub-module, byte_write_ram: single-port, byte-enabled, RAM_LATENCY-stage output pipeline, no reset on contents.

Verification
REQ-035 Write 0xDEADBEEF at 0x40 with strb=0xF, then read 0x40 -> in_ready at cycle 2; out_ready at cycle RAM_LATENCY+2 with data 0xDEADBEEF.
REQ-036 Write 0x11223344 with strb=0x5 over 0xFFFFFFFF -> readback 0xFF22FF44.
REQ-037 Simultaneous write 0xA5A5A5A5 at 0x8 and read 0x8, priority=1 -> write completes first; read returns 0xA5A5A5A5.
REQ-038 priority=0, both ports always valid for 4 transactions -> grants alternate W,R,W,R.
REQ-039 ADDR_WIDTH=4, write 0x7 at byte 0x40, read 0x0 -> returns 0x7 (wrap).
REQ-040 reset=0 during READ_WAIT -> no out_ready pulse; all outputs per REQ-031; a new read succeeds after reset.
